// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals between mem_arbiter and its
// two requesters plus a single-port RAM with combinational read data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter and IDLE/ACCESS/DONE sequencer for a single-port RAM.
// Define ROUND_ROBIN_EN for round-robin tie breaking; default is fixed priority (port 0).
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_win;
  logic              r_done0;
  logic              r_done1;
  logic              r_busy;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;

`ifdef ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie the port not granted last wins; a lone requester always wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_start) begin
      r_last_grant <= w_win;
    end
  end
`else
  assign w_win = ~bus.req0;
`endif

  assign w_we    = w_win ? bus.we1    : bus.we0;
  assign w_addr  = w_win ? bus.addr1  : bus.addr0;
  assign w_wdata = w_win ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_state_nxt = ACCESS;
          w_start     = 1'b1;
        end
      end
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM controls are registered so they stay glitch-free across the whole ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_win       <= w_win;
            r_mem_read  <= ~w_we;
            r_mem_write <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end
        end
        ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          if (r_mem_read) begin
            r_rdata <= bus.mem_rdata;
          end
          r_done0 <= ~r_win;
          r_done1 <= r_win;
        end
        default: ;
      endcase
    end
  end

  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.busy      = r_busy;
  assign bus.rdata     = r_rdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
